// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one Avalon-MM bridge slave between an instruction
// fetch port (read-only) and a data port (read/write).
// Ports:
//   clk_clk, reset_reset_n        : clock, async active-low reset
//   i_*                           : fetch master side (read, address, waitrequest, readdata, readdatavalid)
//   d_*                           : data master side (read, write, address, writedata, byteenable, ...)
//   m_*                           : bridge master side toward mm_bridge_s
//   pend_cnt                      : number of outstanding reads
//   err_rdv                       : sticky flag, readdatavalid seen with no outstanding read
// Commands pass through combinationally under round-robin arbitration.
// A tag FIFO records which requester issued each read so that every returned beat is routed back
// to the requester that issued it.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_W   = 27,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_PEND = 4
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  input  logic                        i_read,
  input  logic [ADDR_W-1:0]           i_address,
  output logic                        i_waitrequest,
  output logic [DATA_W-1:0]           i_readdata,
  output logic                        i_readdatavalid,
  input  logic                        d_read,
  input  logic                        d_write,
  input  logic [ADDR_W-1:0]           d_address,
  input  logic [DATA_W-1:0]           d_writedata,
  input  logic [DATA_W/8-1:0]         d_byteenable,
  output logic                        d_waitrequest,
  output logic [DATA_W-1:0]           d_readdata,
  output logic                        d_readdatavalid,
  output logic [ADDR_W-1:0]           m_address,
  output logic                        m_read,
  output logic                        m_write,
  output logic [DATA_W-1:0]           m_writedata,
  output logic [DATA_W/8-1:0]         m_byteenable,
  output logic                        m_burstcount,
  output logic                        m_debugaccess,
  input  logic                        m_waitrequest,
  input  logic [DATA_W-1:0]           m_readdata,
  input  logic                        m_readdatavalid,
  output logic [$clog2(MAX_PEND):0]   pend_cnt,
  output logic                        err_rdv
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned PTR_W = $clog2(MAX_PEND);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Requester encoding: 0 = fetch, 1 = data
  logic                lock;
  logic                owner;
  logic                last;
  logic [MAX_PEND-1:0] tag_q;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;

  logic full;
  logic empty;
  logic i_elig;
  logic d_elig;
  logic gnt_vld;
  logic gnt_d;
  logic cmd;
  logic accept;
  logic push;
  logic pop;
  logic head;

  assign full   = (pend_cnt == CNT_W'(MAX_PEND));
  assign empty  = (pend_cnt == '0);
  // Full check uses the registered count; a same-cycle pop does not unblock a read
  assign i_elig = i_read && !full;
  assign d_elig = d_write || (d_read && !full);

  // Arbitration: a stalled command keeps the bridge; otherwise round-robin on last acceptance
  always_comb begin
    gnt_vld = 1'b0;
    gnt_d   = 1'b0;
    if (!reset_reset_n) begin
      gnt_vld = 1'b0;
    end else if (lock) begin
      gnt_vld = 1'b1;
      gnt_d   = owner;
    end else if (i_elig && d_elig) begin
      gnt_vld = 1'b1;
      gnt_d   = ~last;
    end else if (i_elig) begin
      gnt_vld = 1'b1;
    end else if (d_elig) begin
      gnt_vld = 1'b1;
      gnt_d   = 1'b1;
    end
  end

  // Command mux; a simultaneous data read+write is treated as a write
  assign m_read        = gnt_vld && (gnt_d ? (d_read && !d_write) : i_read);
  assign m_write       = gnt_vld && gnt_d && d_write;
  assign m_address     = gnt_d ? d_address : i_address;
  assign m_writedata   = d_writedata;
  assign m_byteenable  = gnt_d ? d_byteenable : {BE_W{1'b1}};
  assign m_burstcount  = 1'b1;
  assign m_debugaccess = 1'b0;

  assign cmd    = m_read || m_write;
  assign accept = cmd && !m_waitrequest;
  assign push   = accept && m_read;

  assign i_waitrequest = !(accept && !gnt_d);
  assign d_waitrequest = !(accept && gnt_d);

  // Return routing; a beat with nothing outstanding is dropped and flagged
  assign pop             = m_readdatavalid && !empty;
  assign head            = tag_q[rd_ptr];
  assign i_readdatavalid = pop && !head;
  assign d_readdatavalid = pop && head;
  assign i_readdata      = m_readdata;
  assign d_readdata      = m_readdata;

  // Arbitration state
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      lock  <= 1'b0;
      owner <= 1'b0;
      last  <= 1'b1;
    end else begin
      lock <= cmd && m_waitrequest;
      if (cmd && m_waitrequest) begin
        owner <= gnt_d;
      end
      if (accept) begin
        last <= gnt_d;
      end
    end
  end

  // Tag FIFO, outstanding count and spurious-return flag
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tag_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pend_cnt <= '0;
      err_rdv  <= 1'b0;
    end else begin
      if (push) begin
        tag_q[wr_ptr] <= gnt_d;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   pend_cnt <= pend_cnt + CNT_W'(1);
        2'b01:   pend_cnt <= pend_cnt - CNT_W'(1);
        default: pend_cnt <= pend_cnt;
      endcase
      if (m_readdatavalid && empty) begin
        err_rdv <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed scenarios plus randomized traffic checked against a
// queue-based reference model of the arbiter.
module tb_sdram_port_arbiter;

  localparam int unsigned ADDR_W   = 27;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_PEND = 4;
  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned CNT_W    = $clog2(MAX_PEND) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic              i_waitrequest;
  logic [DATA_W-1:0] i_readdata;
  logic              i_readdatavalid;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_writedata;
  logic [BE_W-1:0]   d_byteenable;
  logic              d_waitrequest;
  logic [DATA_W-1:0] d_readdata;
  logic              d_readdatavalid;
  logic [ADDR_W-1:0] m_address;
  logic              m_read;
  logic              m_write;
  logic [DATA_W-1:0] m_writedata;
  logic [BE_W-1:0]   m_byteenable;
  logic              m_burstcount;
  logic              m_debugaccess;
  logic              m_waitrequest;
  logic [DATA_W-1:0] m_readdata;
  logic              m_readdatavalid;
  logic [CNT_W-1:0]  pend_cnt;
  logic              err_rdv;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_waitrequest(i_waitrequest),
    .i_readdata(i_readdata), .i_readdatavalid(i_readdatavalid),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .d_readdatavalid(d_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_burstcount(m_burstcount), .m_debugaccess(m_debugaccess),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .pend_cnt(pend_cnt), .err_rdv(err_rdv)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: outstanding reads as a queue of requester ids (0 = I, 1 = D)
  bit q[$];
  bit lock_m, owner_m, last_m, err_m;
  bit exp_gv, exp_gd, exp_rd, exp_wr, exp_acc;

  // Evaluate the model mid-cycle and compare every output
  task automatic settle();
    bit full, ie, de, pop_ok, head;
    #3;
    if (!rst_n) begin
      q.delete();
      lock_m = 1'b0;
      last_m = 1'b1;
      err_m  = 1'b0;
    end
    full = (q.size() == MAX_PEND);
    ie   = i_read && !full;
    de   = d_write || (d_read && !full);
    exp_gv = 1'b0;
    exp_gd = 1'b0;
    if (rst_n) begin
      if (lock_m)        begin exp_gv = 1'b1; exp_gd = owner_m; end
      else if (ie && de) begin exp_gv = 1'b1; exp_gd = !last_m; end
      else if (ie)       begin exp_gv = 1'b1; exp_gd = 1'b0;    end
      else if (de)       begin exp_gv = 1'b1; exp_gd = 1'b1;    end
    end
    exp_rd  = exp_gv && (exp_gd ? (d_read && !d_write) : i_read);
    exp_wr  = exp_gv && exp_gd && d_write;
    exp_acc = (exp_rd || exp_wr) && !m_waitrequest;
    pop_ok  = rst_n && m_readdatavalid && (q.size() > 0);
    head    = pop_ok ? q[0] : 1'b0;

    check("m_read", m_read, exp_rd);
    check("m_write", m_write, exp_wr);
    if (exp_rd || exp_wr) check("m_address", m_address, exp_gd ? d_address : i_address);
    if (exp_wr) begin
      check("m_writedata", m_writedata, d_writedata);
      check("m_byteenable", m_byteenable, d_byteenable);
    end
    if (exp_rd && !exp_gd) check("m_byteenable_i", m_byteenable, {BE_W{1'b1}});
    check("i_waitrequest", i_waitrequest, !(exp_acc && !exp_gd));
    check("d_waitrequest", d_waitrequest, !(exp_acc && exp_gd));
    check("i_readdatavalid", i_readdatavalid, pop_ok && !head);
    check("d_readdatavalid", d_readdatavalid, pop_ok && head);
    if (pop_ok) check("readdata", head ? d_readdata : i_readdata, m_readdata);
    check("pend_cnt", pend_cnt, q.size());
    check("err_rdv", err_rdv, err_m);
  endtask

  // Clock edge: advance the model with the inputs that were applied
  task automatic advance();
    @(posedge clk);
    if (rst_n) begin
      if (m_readdatavalid) begin
        if (q.size() > 0) void'(q.pop_front());
        else err_m = 1'b1;
      end
      if (exp_acc) begin
        last_m = exp_gd;
        if (exp_rd) q.push_back(exp_gd);
      end
      lock_m = (exp_rd || exp_wr) && m_waitrequest;
      if (lock_m) owner_m = exp_gd;
    end
    #1;
  endtask

  task automatic idle_inputs();
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0; d_byteenable = '0;
    m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    settle();
    check("rst_i_wait", i_waitrequest, 1'b1);
    check("rst_d_wait", d_waitrequest, 1'b1);
    check("rst_m_read", m_read, 1'b0);
    check("rst_pend", pend_cnt, 0);
    check("burstcount", m_burstcount, 1'b1);
    check("debugaccess", m_debugaccess, 1'b0);
    advance();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      m_readdatavalid = 1'b1;
      m_readdata = DATA_W'($urandom);
      settle();
      advance();
    end
    m_readdatavalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    #1;
    do_reset();

    // Single fetch, data returned three cycles after issue
    i_read = 1'b1; i_address = ADDR_W'(32'h100);
    settle();
    check("fetch_m_read", m_read, 1'b1);
    check("fetch_m_addr", m_address, 32'h100);
    advance();
    i_read = 1'b0;
    settle(); advance();
    settle(); advance();
    m_readdatavalid = 1'b1; m_readdata = 32'hDEADBEEF;
    settle();
    check("fetch_data", i_readdata, 32'hDEADBEEF);
    check("fetch_rdv", i_readdatavalid, 1'b1);
    check("fetch_d_rdv", d_readdatavalid, 1'b0);
    advance();
    m_readdatavalid = 1'b0;
    settle();
    check("fetch_rdv_pulse", i_readdatavalid, 1'b0);
    advance();

    // Contention from reset: I, D, I, D
    do_reset();
    i_read = 1'b1; d_read = 1'b1;
    i_address = ADDR_W'(32'h10); d_address = ADDR_W'(32'h20);
    for (int k = 0; k < 4; k++) begin
      settle();
      check("rr_i_gnt", !i_waitrequest, (k % 2) == 0);
      check("rr_d_gnt", !d_waitrequest, (k % 2) == 1);
      advance();
    end
    i_read = 1'b0; d_read = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_readdatavalid = 1'b1; m_readdata = DATA_W'(k + 1);
      settle();
      check("rr_ret_i", i_readdatavalid, (k % 2) == 0);
      check("rr_ret_d", d_readdatavalid, (k % 2) == 1);
      advance();
    end
    m_readdatavalid = 1'b0;

    // Stall lock: D write held for 4 stalled cycles while I requests
    do_reset();
    d_write = 1'b1; d_address = ADDR_W'(32'h55); d_writedata = 32'h1234_5678; d_byteenable = 4'h3;
    m_waitrequest = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("lock_m_write", m_write, 1'b1);
      check("lock_m_addr", m_address, 32'h55);
      check("lock_i_wait", i_waitrequest, 1'b1);
      advance();
      i_read = 1'b1; i_address = ADDR_W'(32'h200);
    end
    m_waitrequest = 1'b0;
    settle();
    check("lock_d_acc", d_waitrequest, 1'b0);
    check("lock_i_held", i_waitrequest, 1'b1);
    advance();
    d_write = 1'b0;
    settle();
    check("lock_i_acc", i_waitrequest, 1'b0);
    check("lock_i_addr", m_address, 32'h200);
    advance();
    i_read = 1'b0;
    drain(1);

    // Full FIFO: fifth read held even with a same-cycle return; write passes
    do_reset();
    i_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_address = ADDR_W'(k * 4);
      settle(); advance();
    end
    i_address = ADDR_W'(32'h40);
    d_write = 1'b1; d_address = ADDR_W'(32'h80); d_writedata = 32'hCAFE; d_byteenable = 4'hF;
    m_readdatavalid = 1'b1; m_readdata = 32'h1;
    settle();
    check("full_pend", pend_cnt, 4);
    check("full_i_held", i_waitrequest, 1'b1);
    check("full_d_write", d_waitrequest, 1'b0);
    advance();
    d_write = 1'b0; m_readdatavalid = 1'b0;
    settle();
    check("full_pend3", pend_cnt, 3);
    check("full_i_issue", i_waitrequest, 1'b0);
    advance();
    i_read = 1'b0;
    drain(4);

    // Spurious readdatavalid
    m_readdatavalid = 1'b1;
    settle(); advance();
    m_readdatavalid = 1'b0;
    settle();
    check("spur_err", err_rdv, 1'b1);
    check("spur_pend", pend_cnt, 0);
    advance();
    settle();
    check("spur_sticky", err_rdv, 1'b1);
    advance();

    // Reset mid-operation with two reads outstanding
    do_reset();
    i_read = 1'b1;
    settle(); advance();
    settle(); advance();
    rst_n = 1'b0;
    settle();
    check("midrst_pend", pend_cnt, 0);
    check("midrst_i_wait", i_waitrequest, 1'b1);
    check("midrst_d_wait", d_waitrequest, 1'b1);
    advance();
    i_read = 1'b0;
    rst_n = 1'b1;
    m_readdatavalid = 1'b1;
    settle(); advance();
    m_readdatavalid = 1'b0;
    settle();
    check("midrst_err", err_rdv, 1'b1);
    advance();

    // Randomized traffic with well-behaved masters that hold commands until accepted
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit i_acc, d_acc;
      if (!i_read && $urandom_range(0, 2) == 0) begin
        i_read = 1'b1; i_address = ADDR_W'($urandom);
      end
      if (!d_read && !d_write && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) d_write = 1'b1; else d_read = 1'b1;
        d_address = ADDR_W'($urandom); d_writedata = DATA_W'($urandom);
        d_byteenable = BE_W'($urandom);
      end
      m_waitrequest   = ($urandom_range(0, 3) == 0);
      m_readdatavalid = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      m_readdata      = DATA_W'($urandom);
      settle();
      i_acc = exp_acc && !exp_gd;
      d_acc = exp_acc && exp_gd;
      advance();
      if (i_acc) i_read = 1'b0;
      if (d_acc) begin d_read = 1'b0; d_write = 1'b0; end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
